// File: rtl/preamble_peak_detector.sv
// Preamble plateau peak detector: a two-stage pass-through pipeline that marks the
// peak beat of each qualifying correlator plateau with o_tlast and reports the CFO phase.
module preamble_peak_detector #(
   parameter int WIDTH      = 32,
   parameter int WINDOW_LEN = 64,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             cfg_enable,
   input  logic [15:0]      cfg_thresh,
   input  logic [15:0]      cfg_min_power,
   input  logic [CNT_W-1:0] cfg_min_run,
   input  logic [CNT_W-1:0] cfg_holdoff,
   input  logic [15:0]      i_mag,
   input  logic [15:0]      i_phase,
   input  logic [15:0]      i_power,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic [15:0]      o_phase,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready,
   output logic [31:0]      o_det_count
);

   localparam int PH_SHIFT = $clog2(WINDOW_LEN);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   logic [31:0]        w_prod;
   logic [15:0]        w_scaled;
   logic signed [17:0] w_metric;
   logic               w_trig;
   logic [15:0]        w_phase_sh;
   logic               w_s2_free;
   logic               w_s1_xfer;
   logic               w_s1_free;
   logic               w_s1_load;

   logic               r_s1_valid;
   logic [WIDTH-1:0]   r_s1_data;
   logic [15:0]        r_s1_phase;
   logic signed [17:0] r_s1_metric;
   logic               r_s1_trig;

   logic               r_s2_valid;
   logic [WIDTH-1:0]   r_s2_data;
   logic [15:0]        r_s2_phase;
   logic               r_s2_last;

   state_t             r_state;
   logic signed [17:0] r_prev_metric;
   logic signed [18:0] r_prev_diff;
   logic [CNT_W-1:0]   r_run_cnt;
   logic [CNT_W-1:0]   r_hold_cnt;
   logic [31:0]        r_det_count;

   state_t             w_nxt_state;
   logic signed [17:0] w_nxt_prev_metric;
   logic signed [18:0] w_nxt_prev_diff;
   logic [CNT_W-1:0]   w_nxt_run;
   logic [CNT_W-1:0]   w_nxt_hold;
   logic               w_detect;
   logic signed [18:0] w_diff;
   logic               w_zc;
   logic [CNT_W-1:0]   w_run_inc;

   // Metric: |P| minus the power scaled by sqrt(D); positive means above threshold.
   assign w_prod     = {16'd0, i_power} * {16'd0, cfg_thresh};
   assign w_scaled   = 16'(w_prod >> 16);
   assign w_metric   = {2'b00, i_mag} - {2'b00, w_scaled};
   assign w_trig     = (w_metric > 18'sd0) && (i_power > cfg_min_power);
   assign w_phase_sh = 16'($signed(i_phase) >>> PH_SHIFT);

   assign w_s2_free = !r_s2_valid || o_tready;
   assign w_s1_xfer = r_s1_valid && w_s2_free;
   assign w_s1_free = !r_s1_valid || w_s1_xfer;
   assign w_s1_load = i_tvalid && w_s1_free;
   assign i_tready  = w_s1_free;

   assign w_diff    = {r_s1_metric[17], r_s1_metric} - {r_prev_metric[17], r_prev_metric};
   assign w_zc      = r_s1_trig && (w_diff <= 19'sd0) && (r_prev_diff > 19'sd0);
   assign w_run_inc = (r_run_cnt == {CNT_W{1'b1}}) ? r_run_cnt : r_run_cnt + CNT_W'(1);

   assign o_tdata     = r_s2_data;
   assign o_phase     = r_s2_phase;
   assign o_tlast     = r_s2_last;
   assign o_tvalid    = r_s2_valid;
   assign o_det_count = r_det_count;

   // Peak-tracking next state, evaluated for the beat currently held in S1.
   always_comb begin
      w_nxt_state       = r_state;
      w_nxt_prev_metric = r_prev_metric;
      w_nxt_prev_diff   = r_prev_diff;
      w_nxt_run         = r_run_cnt;
      w_nxt_hold        = r_hold_cnt;
      w_detect          = 1'b0;
      if (!cfg_enable) begin
         w_nxt_state       = ST_IDLE;
         w_nxt_prev_metric = 18'sd0;
         w_nxt_prev_diff   = 19'sd0;
         w_nxt_run         = {CNT_W{1'b0}};
         w_nxt_hold        = {CNT_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_s1_trig) begin
                  w_nxt_state       = ST_RUN;
                  w_nxt_run         = CNT_W'(1);
                  w_nxt_prev_metric = r_s1_metric;
                  w_nxt_prev_diff   = w_diff;
               end else begin
                  w_nxt_run         = {CNT_W{1'b0}};
                  w_nxt_prev_metric = 18'sd0;
                  w_nxt_prev_diff   = 19'sd0;
               end
            end
            ST_RUN: begin
               if (!r_s1_trig) begin
                  w_nxt_state       = ST_IDLE;
                  w_nxt_run         = {CNT_W{1'b0}};
                  w_nxt_prev_metric = 18'sd0;
                  w_nxt_prev_diff   = 19'sd0;
               end else begin
                  w_nxt_run         = w_run_inc;
                  w_nxt_prev_metric = r_s1_metric;
                  w_nxt_prev_diff   = w_diff;
                  if (w_zc && (w_run_inc >= cfg_min_run)) begin
                     w_detect    = 1'b1;
                     w_nxt_hold  = cfg_holdoff;
                     w_nxt_state = (cfg_holdoff == {CNT_W{1'b0}}) ? ST_IDLE : ST_HOLDOFF;
                  end else begin
                     w_nxt_state = ST_RUN;
                  end
               end
            end
            ST_HOLDOFF: begin
               w_nxt_run         = {CNT_W{1'b0}};
               w_nxt_prev_metric = 18'sd0;
               w_nxt_prev_diff   = 19'sd0;
               if (r_hold_cnt <= CNT_W'(1)) begin
                  w_nxt_state = ST_IDLE;
                  w_nxt_hold  = {CNT_W{1'b0}};
               end else begin
                  w_nxt_hold  = r_hold_cnt - CNT_W'(1);
               end
            end
            default: begin
               w_nxt_state       = ST_IDLE;
               w_nxt_run         = {CNT_W{1'b0}};
               w_nxt_hold        = {CNT_W{1'b0}};
               w_nxt_prev_metric = 18'sd0;
               w_nxt_prev_diff   = 19'sd0;
            end
         endcase
      end
   end

   // Two-stage elastic pipeline; o_tlast is decided as a beat moves into S2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_data   <= {WIDTH{1'b0}};
         r_s1_phase  <= 16'd0;
         r_s1_metric <= 18'sd0;
         r_s1_trig   <= 1'b0;
         r_s2_valid  <= 1'b0;
         r_s2_data   <= {WIDTH{1'b0}};
         r_s2_phase  <= 16'd0;
         r_s2_last   <= 1'b0;
      end else if (clear) begin
         r_s1_valid  <= 1'b0;
         r_s1_trig   <= 1'b0;
         r_s2_valid  <= 1'b0;
         r_s2_last   <= 1'b0;
      end else begin
         if (w_s1_load) begin
            r_s1_valid  <= 1'b1;
            r_s1_data   <= i_tdata;
            r_s1_phase  <= w_phase_sh;
            r_s1_metric <= w_metric;
            r_s1_trig   <= w_trig;
         end else if (w_s1_xfer) begin
            r_s1_valid  <= 1'b0;
         end
         if (w_s1_xfer) begin
            r_s2_valid <= 1'b1;
            r_s2_data  <= r_s1_data;
            r_s2_phase <= r_s1_phase;
            r_s2_last  <= w_detect;
         end else if (o_tready) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
         end
      end
   end

   // Detector state advances only when a beat actually transfers S1->S2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_prev_metric <= 18'sd0;
         r_prev_diff   <= 19'sd0;
         r_run_cnt     <= {CNT_W{1'b0}};
         r_hold_cnt    <= {CNT_W{1'b0}};
         r_det_count   <= 32'd0;
      end else if (clear) begin
         r_state       <= ST_IDLE;
         r_prev_metric <= 18'sd0;
         r_prev_diff   <= 19'sd0;
         r_run_cnt     <= {CNT_W{1'b0}};
         r_hold_cnt    <= {CNT_W{1'b0}};
         r_det_count   <= 32'd0;
      end else if (w_s1_xfer) begin
         r_state       <= w_nxt_state;
         r_prev_metric <= w_nxt_prev_metric;
         r_prev_diff   <= w_nxt_prev_diff;
         r_run_cnt     <= w_nxt_run;
         r_hold_cnt    <= w_nxt_hold;
         if (w_detect) begin
            r_det_count <= r_det_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_preamble_peak_detector.sv
// Directed self-checking bench for preamble_peak_detector: bypass, peak, plateau length,
// holdoff, power gating, backpressure and asynchronous reset.
module tb_preamble_peak_detector;

   logic        clk = 1'b0;
   logic        reset, clear, cfg_enable;
   logic [15:0] cfg_thresh, cfg_min_power, cfg_min_run, cfg_holdoff;
   logic [15:0] i_mag, i_phase, i_power;
   logic [31:0] i_tdata;
   logic        i_tvalid, i_tready;
   logic [31:0] o_tdata;
   logic [15:0] o_phase;
   logic        o_tlast, o_tvalid, o_tready;
   logic [31:0] o_det_count;

   typedef struct {
      logic [31:0] data;
      logic [15:0] phase;
      logic        last;
   } beat_t;

   beat_t       cap_q[$];
   logic [31:0] sent_q[$];
   logic [15:0] v_mag[1024];
   logic [15:0] v_phase[1024];
   logic [15:0] v_power[1024];
   logic [31:0] data_ctr = 32'h1000_0000;
   int          n_checks = 0;
   int          n_fail = 0;
   int          rdy_pct = 100;
   bit          chk_stall = 1'b0;
   int          stall_viol = 0;
   int          orphan_last = 0;

   always #5 clk = ~clk;

   preamble_peak_detector #(.WIDTH(32), .WINDOW_LEN(64), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .clear(clear), .cfg_enable(cfg_enable),
      .cfg_thresh(cfg_thresh), .cfg_min_power(cfg_min_power),
      .cfg_min_run(cfg_min_run), .cfg_holdoff(cfg_holdoff),
      .i_mag(i_mag), .i_phase(i_phase), .i_power(i_power), .i_tdata(i_tdata),
      .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_phase(o_phase), .o_tlast(o_tlast),
      .o_tvalid(o_tvalid), .o_tready(o_tready), .o_det_count(o_det_count)
   );

   // o_tready changes just after the active edge so it is stable when sampled.
   initial begin
      o_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         o_tready = (rdy_pct >= 100) ? 1'b1 : ((int'($urandom_range(99)) < rdy_pct) ? 1'b1 : 1'b0);
      end
   end

   // Output monitor, sampling on the falling edge.
   initial begin
      logic pv, pr, pl;
      logic [31:0] pd;
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 32'd0;
      forever begin
         @(negedge clk);
         if (o_tlast && !o_tvalid) orphan_last++;
         if (chk_stall && pv && !pr && (o_tvalid !== 1'b1 || o_tdata !== pd || o_tlast !== pl)) stall_viol++;
         pv = o_tvalid; pr = o_tready; pd = o_tdata; pl = o_tlast;
         if (!reset && o_tvalid && o_tready) cap_q.push_back('{o_tdata, o_phase, o_tlast});
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] last_mask();
      logic [31:0] m;
      m = 32'd0;
      foreach (cap_q[i]) if (cap_q[i].last && i < 32) m[i] = 1'b1;
      return m;
   endfunction

   function automatic int data_errs();
      int e;
      e = (cap_q.size() == sent_q.size()) ? 0 : 1;
      foreach (cap_q[i]) if (i < sent_q.size() && cap_q[i].data !== sent_q[i]) e++;
      return e;
   endfunction

   task automatic set_cfg(input logic en, input logic [15:0] th, input logic [15:0] mp,
                          input logic [15:0] mr, input logic [15:0] ho);
      cfg_enable = en; cfg_thresh = th; cfg_min_power = mp; cfg_min_run = mr; cfg_holdoff = ho;
   endtask

   task automatic do_clear();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
   endtask

   task automatic load_peak();
      logic [15:0] m[7];
      logic signed [15:0] p[7];
      m = '{16'd10, 16'd40, 16'd80, 16'd100, 16'd90, 16'd60, 16'd0};
      p = '{16'sd640, -16'sd640, 16'sd32767, 16'sd1000, -16'sd1000, 16'sd63, -16'sd1};
      for (int i = 0; i < 7; i++) begin
         v_mag[i] = m[i]; v_phase[i] = p[i]; v_power[i] = 16'd100;
      end
   endtask

   task automatic send_beats(input int n);
      int guard;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         i_tvalid = 1'b1; i_mag = v_mag[i]; i_phase = v_phase[i]; i_power = v_power[i];
         i_tdata = data_ctr;
         #1;
         guard = 0;
         while (!i_tready && guard < 2000) begin
            @(negedge clk); #1; guard++;
         end
         sent_q.push_back(data_ctr);
         data_ctr = data_ctr + 32'd1;
         @(posedge clk);
      end
      @(negedge clk);
      i_tvalid = 1'b0;
   endtask

   task automatic run_seq(input int n);
      int g;
      cap_q.delete(); sent_q.delete();
      send_beats(n);
      g = 0;
      while (cap_q.size() < n && g < 5000) begin
         @(negedge clk); g++;
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; clear = 1'b0; i_tvalid = 1'b0; i_mag = 16'd0; i_phase = 16'd0;
      i_power = 16'd0; i_tdata = 32'd0;
      set_cfg(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
      repeat (3) @(negedge clk);
      n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", o_tvalid); end
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (o_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b want 0", o_tlast); end
      n_checks++; if (o_det_count !== 32'd0) begin n_fail++; $display("FAIL reset_det got %0d want 0", o_det_count); end
      n_checks++; if (i_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready got %b want 1", i_tready); end
   endtask

   task automatic test_bypass();
      logic [15:0] m[7];
      int nl;
      m = '{16'd10, 16'd40, 16'd80, 16'd100, 16'd90, 16'd60, 16'd0};
      for (int i = 0; i < 1000; i++) begin
         v_mag[i] = m[i % 7]; v_phase[i] = 16'(i); v_power[i] = 16'd100;
      end
      set_cfg(1'b0, 16'hD62C, 16'd32, 16'd1, 16'd0);
      rdy_pct = 50;
      do_clear();
      run_seq(1000);
      rdy_pct = 100;
      n_checks++; if (cap_q.size() !== 1000) begin n_fail++; $display("FAIL bypass_count got %0d want 1000", cap_q.size()); end
      nl = 0;
      foreach (cap_q[i]) begin
         if (cap_q[i].last) nl++;
         n_checks++;
         if (i < sent_q.size() && cap_q[i].data !== sent_q[i]) begin
            n_fail++; $display("FAIL bypass_data[%0d] got %h want %h", i, cap_q[i].data, sent_q[i]);
         end
      end
      n_checks++; if (nl !== 0) begin n_fail++; $display("FAIL bypass_tlast got %0d want 0", nl); end
      n_checks++; if (o_det_count !== 32'd0) begin n_fail++; $display("FAIL bypass_det got %0d want 0", o_det_count); end
   endtask

   task automatic test_single_peak(input string tag);
      logic [15:0] e_ph[7];
      e_ph = '{16'd10, 16'hFFF6, 16'd511, 16'd15, 16'hFFF0, 16'd0, 16'hFFFF};
      set_cfg(1'b1, 16'hD62C, 16'd32, 16'd2, 16'd0);
      do_clear();
      load_peak();
      run_seq(7);
      n_checks++; if (cap_q.size() !== 7) begin n_fail++; $display("FAIL %s_count got %0d want 7", tag, cap_q.size()); end
      n_checks++; if (data_errs() !== 0) begin n_fail++; $display("FAIL %s_data got %0d errors want 0", tag, data_errs()); end
      n_checks++; if (last_mask() !== 32'h10) begin n_fail++; $display("FAIL %s_tlast got %h want 00000010", tag, last_mask()); end
      for (int i = 0; i < 7; i++) begin
         n_checks++;
         if (i < cap_q.size() && cap_q[i].phase !== e_ph[i]) begin
            n_fail++; $display("FAIL %s_phase[%0d] got %h want %h", tag, i, cap_q[i].phase, e_ph[i]);
         end
      end
      n_checks++; if (o_det_count !== 32'd1) begin n_fail++; $display("FAIL %s_det got %0d want 1", tag, o_det_count); end
   endtask

   task automatic test_short_plateau();
      // Only the 100 and 90 beats trigger, so the plateau is two beats long.
      set_cfg(1'b1, 16'hD62C, 16'd32, 16'd8, 16'd0);
      do_clear(); load_peak(); run_seq(7);
      n_checks++; if (last_mask() !== 32'h0) begin n_fail++; $display("FAIL short8_tlast got %h want 0", last_mask()); end
      n_checks++; if (o_det_count !== 32'd0) begin n_fail++; $display("FAIL short8_det got %0d want 0", o_det_count); end
      set_cfg(1'b1, 16'hD62C, 16'd32, 16'd3, 16'd0);
      do_clear(); load_peak(); run_seq(7);
      n_checks++; if (last_mask() !== 32'h0) begin n_fail++; $display("FAIL short3_tlast got %h want 0", last_mask()); end
      set_cfg(1'b1, 16'hD62C, 16'd32, 16'd1, 16'd0);
      do_clear(); load_peak(); run_seq(7);
      n_checks++; if (last_mask() !== 32'h10) begin n_fail++; $display("FAIL short1_tlast got %h want 00000010", last_mask()); end
      n_checks++; if (o_det_count !== 32'd1) begin n_fail++; $display("FAIL short1_det got %0d want 1", o_det_count); end
   endtask

   task automatic test_holdoff();
      logic [15:0] m[12];
      m = '{16'd10, 16'd100, 16'd90, 16'd10, 16'd10, 16'd10, 16'd100, 16'd90,
            16'd10, 16'd10, 16'd10, 16'd10};
      for (int i = 0; i < 12; i++) begin
         v_mag[i] = m[i]; v_phase[i] = 16'd0; v_power[i] = 16'd100;
      end
      set_cfg(1'b1, 16'hD62C, 16'd32, 16'd2, 16'd10);
      do_clear(); run_seq(12);
      n_checks++; if (last_mask() !== 32'h4) begin n_fail++; $display("FAIL hold10_tlast got %h want 00000004", last_mask()); end
      n_checks++; if (o_det_count !== 32'd1) begin n_fail++; $display("FAIL hold10_det got %0d want 1", o_det_count); end
      set_cfg(1'b1, 16'hD62C, 16'd32, 16'd2, 16'd3);
      do_clear(); run_seq(12);
      n_checks++; if (last_mask() !== 32'h84) begin n_fail++; $display("FAIL hold3_tlast got %h want 00000084", last_mask()); end
      n_checks++; if (o_det_count !== 32'd2) begin n_fail++; $display("FAIL hold3_det got %0d want 2", o_det_count); end
   endtask

   task automatic test_low_power();
      logic [15:0] m[5];
      // scaled(20) = 16, metrics 4,14,9,14,-6: only the power gate can block these.
      m = '{16'd20, 16'd30, 16'd25, 16'd30, 16'd10};
      for (int i = 0; i < 5; i++) begin
         v_mag[i] = m[i]; v_phase[i] = 16'd0; v_power[i] = 16'd20;
      end
      set_cfg(1'b1, 16'hD62C, 16'd32, 16'd1, 16'd0);
      do_clear(); run_seq(5);
      n_checks++; if (last_mask() !== 32'h0) begin n_fail++; $display("FAIL lowpow32_tlast got %h want 0", last_mask()); end
      n_checks++; if (o_det_count !== 32'd0) begin n_fail++; $display("FAIL lowpow32_det got %0d want 0", o_det_count); end
      set_cfg(1'b1, 16'hD62C, 16'd20, 16'd1, 16'd0);
      do_clear(); run_seq(5);
      n_checks++; if (last_mask() !== 32'h0) begin n_fail++; $display("FAIL lowpow20_tlast got %h want 0", last_mask()); end
      set_cfg(1'b1, 16'hD62C, 16'd19, 16'd1, 16'd0);
      do_clear(); run_seq(5);
      n_checks++; if (last_mask() !== 32'h4) begin n_fail++; $display("FAIL lowpow19_tlast got %h want 00000004", last_mask()); end
   endtask

   task automatic test_backpressure();
      rdy_pct = 30; chk_stall = 1'b1; stall_viol = 0; orphan_last = 0;
      test_single_peak("bp");
      chk_stall = 1'b0; rdy_pct = 100;
      repeat (3) @(negedge clk);
      n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stall_hold got %0d want 0", stall_viol); end
      n_checks++; if (orphan_last !== 0) begin n_fail++; $display("FAIL bp_orphan_tlast got %0d want 0", orphan_last); end
   endtask

   task automatic test_reset_mid();
      set_cfg(1'b1, 16'hD62C, 16'd32, 16'd2, 16'd0);
      do_clear(); load_peak();
      cap_q.delete(); sent_q.delete();
      send_beats(4);
      n_checks++; if (o_tvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_tvalid got %b want 1", o_tvalid); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid got %b want 0", o_tvalid); end
      n_checks++; if (o_det_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_det got %0d want 0", o_det_count); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      test_single_peak("restart");
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_single_peak("peak");
      test_short_plateau();
      test_holdoff();
      test_low_power();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
